// File: rtl/aes_word_stream_frontend.sv
// Word-serial front end for an iterative AES-128 core. It gathers key and plaintext from a 32-bit
// stream, launches the core, and returns the 128-bit result as four MS-first words.
module aes_word_stream_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [31:0]  s_data_i,
    input  logic         s_is_key_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [127:0] core_plain_o,
    output logic [127:0] core_key_o,
    output logic         core_start_o,
    input  logic [127:0] core_result_i,
    input  logic         core_done_i,
    output logic [31:0]  m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic         m_last_o,
    output logic         busy_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_DRAIN} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t       state_q, state_d;
    logic [127:0] key_q, txt_q, result_q;
    logic [2:0]   key_cnt_q, key_cnt_d;
    logic [2:0]   txt_cnt_q, txt_cnt_d;
    logic [1:0]   out_idx_q, out_idx_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic         live_q;
    logic         in_load, key_accept, txt_accept, capture;
    logic [1:0]   key_slot;

    assign in_load = (state_q == ST_LOAD);

    // live_q holds s_ready_o low during reset; it rises on the first edge after release.
    assign s_ready_o  = live_q & in_load & ~(~s_is_key_i & (txt_cnt_q == 3'd4));
    assign key_accept = s_valid_i & s_ready_o & s_is_key_i;
    assign txt_accept = s_valid_i & s_ready_o & ~s_is_key_i;

    // A key word arriving on a complete key restarts the key at the top slot.
    assign key_slot = (key_cnt_q == 3'd4) ? 2'd0 : key_cnt_q[1:0];

    assign core_key_o   = key_q;
    assign core_plain_o = txt_q;
    assign busy_o       = ~in_load;
    assign m_valid_o    = (state_q == ST_DRAIN);
    assign m_last_o     = m_valid_o & (out_idx_q == 2'd3);
    assign m_data_o     = m_valid_o ? result_q[{~out_idx_q, 5'd0} +: 32] : 32'd0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        txt_cnt_d    = txt_cnt_q;
        out_idx_d    = out_idx_q;
        wait_cnt_d   = wait_cnt_q;
        core_start_o = 1'b0;
        timeout_o    = 1'b0;
        capture      = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (key_accept) key_cnt_d = (key_cnt_q == 3'd4) ? 3'd1 : key_cnt_q + 3'd1;
                if (txt_accept) txt_cnt_d = txt_cnt_q + 3'd1;
                if (key_cnt_d == 3'd4 && txt_cnt_d == 3'd4) state_d = ST_START;
            end
            ST_START: begin
                core_start_o = 1'b1;
                wait_cnt_d   = 8'd0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done_i) begin
                    capture = 1'b1;
                    state_d = ST_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_o = 1'b1;
                    txt_cnt_d = 3'd0;
                    state_d   = ST_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (m_ready_i) begin
                    if (out_idx_q == 2'd3) begin
                        out_idx_d = 2'd0;
                        txt_cnt_d = 3'd0;
                        state_d   = ST_LOAD;
                    end else begin
                        out_idx_d = out_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: the data buffers are reset along with the control state; a reset must wipe the stored key
    // and any in-flight result, not just the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_LOAD;
            key_cnt_q  <= 3'd0;
            txt_cnt_q  <= 3'd0;
            out_idx_q  <= 2'd0;
            wait_cnt_q <= 8'd0;
            live_q     <= 1'b0;
            key_q      <= '0;
            txt_q      <= '0;
            result_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            state_q    <= state_d;
            key_cnt_q  <= key_cnt_d;
            txt_cnt_q  <= txt_cnt_d;
            out_idx_q  <= out_idx_d;
            wait_cnt_q <= wait_cnt_d;
            live_q     <= 1'b1;
            if (key_accept) key_q[{~key_slot, 5'd0} +: 32] <= s_data_i;
            if (txt_accept) txt_q[{~txt_cnt_q[1:0], 5'd0} +: 32] <= s_data_i;
            if (capture) result_q <= core_result_i;
        end
    end

endmodule
